instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter BOOT_ADDR, default 32'h0000_0100, byte address of the first fetch after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, number of prefetch buffer entries (power of two, at least 2).
REQ-003 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 fetch_enable_i  input  1  fetch permission; when low, no new memory request is issued.
REQ-006 instr_req_o  input-facing output  1  memory request strobe; the memory samples on its rising edge.
REQ-007 instr_addr_o  output  32  byte address of the current request; bits [1:0] always zero.
REQ-008 instr_rdata_i  input  32  word returned by the memory.
REQ-009 branch_i  input  1  redirect pulse from downstream, one cycle wide.
REQ-010 branch_target_i  input  32  redirect byte address.
REQ-011 instr_valid_o  output  1  FIFO head holds a valid instruction.
REQ-012 instr_ready_i  input  1  decode accepts the head this cycle.
REQ-013 instr_rdata_o  output  32  instruction word at the FIFO head.
REQ-014 instr_pc_o  output  32  byte address of instr_rdata_o.

Function
REQ-015 Memory FSM SHALL have three states:
- IDLE -> REQ when fetch_enable_i=1, FIFO not full, and no branch_i.
- REQ -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-016 instr_req_o SHALL be registered and high only in REQ, so every request is a fresh rising edge; minimum request spacing is 3 cycles.
REQ-017 instr_addr_o SHALL be held at the fetch PC from IDLE exit through the end of RESP.
REQ-018 instr_rdata_i SHALL be captured at the clock edge ending RESP and pushed with its address.
REQ-019 After a push, the fetch PC SHALL advance by 4 and wrap modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-020 A request SHALL be issued only if a FIFO slot is free, counting the in-flight word; the FIFO SHALL never overflow.
REQ-021 Pop SHALL occur when instr_valid_o && instr_ready_i; the head outputs SHALL be stable while valid && !ready.
REQ-022 A simultaneous push and pop on a full FIFO SHALL be legal, with no loss.
REQ-023 A simultaneous push and pop on an empty FIFO SHALL go through the buffer; instr_valid_o rises the cycle after the push.
REQ-024 On branch_i, the FIFO SHALL be flushed that cycle, and the fetch PC SHALL become {branch_target_i[31:2],2'b00}.
REQ-025 A request in flight when branch_i arrives SHALL complete its REQ/RESP sequence, but its word SHALL be discarded.
REQ-026 branch_i SHALL take priority over a same-cycle pop and push.
REQ-027 fetch_enable_i falling SHALL let any in-flight request complete and push normally.

Reset
REQ-028 On rst_ni low:
- state=IDLE, fetch PC=BOOT_ADDR, FIFO empty;
- instr_req_o=0, instr_addr_o=BOOT_ADDR, instr_valid_o=0, instr_rdata_o=0, instr_pc_o=0.
REQ-029 Reset mid-request SHALL abandon the request with no push; the first post-reset request SHALL target BOOT_ADDR.

Structure
REQ-030 Package fetch_pkg SHALL hold the FSM state enum and the default BOOT_ADDR constant.
REQ-031 The FIFO SHALL be a sub-module fetch_fifo (depth parameter; push/pop/flush; full/empty; data+pc payload).
REQ-032 instr_fetch SHALL hold the FSM, the PC register and the discard flag.

Verification
REQ-033 Boot, enable=1, ready=1, memory words 0x100=0x01000093, 0x104=0x01500113, 0x108=0x0020C1B3 -> the three words are output in order with pc 0x100/0x104/0x108, one every 3 cycles.
REQ-034 ready=0 for 20 cycles -> exactly FIFO_DEPTH words are buffered, no further instr_req_o, and the head is stable; ready=1 -> drains in order without loss.
REQ-035 branch_i to 0x203 during REQ -> the in-flight word is dropped and the next output has pc=0x200.
REQ-036 PC=0xFFFF_FFFC -> the next request is to address 0x0000_0000.
REQ-037 rst_ni low during RESP -> nothing is pushed, and after release the first request is to 0x100.
REQ-038 enable dropped during REQ -> that word is still delivered, then no further requests are issued.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    // Memory-side sequencer states: one outstanding request at a time.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0100;

    // One prefetch buffer entry: instruction word plus its byte address.
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } fetch_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Memory request bus and decode-side instruction stream of the fetch unit.
interface instr_fetch_if;

    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic [31:0] instr_rdata_i;

    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_pc_o;

    modport master (
        output instr_req_o,
        output instr_addr_o,
        input  instr_rdata_i,
        output instr_valid_o,
        input  instr_ready_i,
        output instr_rdata_o,
        output instr_pc_o
    );

    modport slave (
        input  instr_req_o,
        input  instr_addr_o,
        output instr_rdata_i,
        input  instr_valid_o,
        output instr_ready_i,
        input  instr_rdata_o,
        input  instr_pc_o
    );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Prefetch buffer: circular FIFO of {data, pc} entries with synchronous flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wentry,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer/occupancy update and entry write; flush empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wentry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory sequencer feeding a
// prefetch buffer, with branch redirect and in-flight word discard.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = BOOT_ADDR_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 fetch_enable_i,
    input  logic                 branch_i,
    input  logic [31:0]          branch_target_i,
    instr_fetch_if.master        bus
);

    fetch_state_e state;
    logic [31:0]  pc_q;
    logic [31:0]  addr_q;
    logic         req_q;
    logic         discard_q;

    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop;
    fetch_entry_t wentry;
    fetch_entry_t head;

    // The word returned in RESP is kept unless a redirect hit it or hits now.
    assign push   = (state == RESP) && !discard_q && !branch_i;
    assign pop    = !fifo_empty && bus.instr_ready_i;
    assign wentry = '{data: bus.instr_rdata_i, pc: addr_q};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .push   (push),
        .pop    (pop),
        .flush  (branch_i),
        .wentry (wentry),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (head)
    );

    assign bus.instr_req_o   = req_q;
    assign bus.instr_addr_o  = addr_q;
    assign bus.instr_valid_o = !fifo_empty;
    assign bus.instr_rdata_o = head.data;
    assign bus.instr_pc_o    = head.pc;

    // Memory sequencer, fetch PC and discard flag. Only one request is ever
    // outstanding and it is pushed before the next IDLE, so "not full" in
    // IDLE already accounts for the in-flight word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            pc_q      <= BOOT_ADDR;
            addr_q    <= BOOT_ADDR;
            req_q     <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            req_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (branch_i) begin
                        pc_q <= word_align(branch_target_i);
                    end else if (fetch_enable_i && !fifo_full) begin
                        state  <= REQ;
                        req_q  <= 1'b1;
                        addr_q <= pc_q;
                    end
                end
                REQ: begin
                    state <= RESP;
                    if (branch_i) begin
                        pc_q      <= word_align(branch_target_i);
                        discard_q <= 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    discard_q <= 1'b0;
                    if (branch_i) begin
                        pc_q <= word_align(branch_target_i);
                    end else if (!discard_q) begin
                        pc_q <= pc_q + 32'd4;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// phase, checked against a sequential instruction-stream reference model.
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] BOOT  = 32'h0000_0100;
    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        branch;
    logic [31:0] target;

    int          vectors     = 0;
    int          miscompares = 0;

    logic [31:0] salt;
    logic [31:0] exp_pc;
    logic [31:0] last_pop_pc;
    int unsigned cycle;
    int unsigned req_cnt;
    int unsigned pop_cnt;
    int unsigned pop_cycles[$];
    logic [31:0] req_log[$];

    instr_fetch_if bus ();

    instr_fetch #(
        .BOOT_ADDR  (BOOT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .fetch_enable_i  (enable),
        .branch_i        (branch),
        .branch_target_i (target),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    // Memory contents: the boot program, elsewhere a salted address hash.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] s);
        case (a)
            32'h0000_0100: return 32'h0100_0093;
            32'h0000_0104: return 32'h0150_0113;
            32'h0000_0108: return 32'h0020_C1B3;
            default:       return (a * 32'h9E37_79B1) ^ s;
        endcase
    endfunction

    // Memory holds its address through RESP, so a combinational read suffices.
    assign bus.instr_rdata_i = mem_word(bus.instr_addr_o, salt);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One clock: evaluate this cycle's handshake against the stream model,
    // log any request, then advance to the next falling edge.
    task automatic tick();
        if (rst_n) begin
            if (bus.instr_req_o) begin
                req_cnt++;
                req_log.push_back(bus.instr_addr_o);
                check("addr_align", {30'd0, bus.instr_addr_o[1:0]}, 32'd0);
            end
            if (bus.instr_valid_o && bus.instr_ready_i && !branch) begin
                check("pop_pc", bus.instr_pc_o, exp_pc);
                check("pop_data", bus.instr_rdata_o, mem_word(exp_pc, salt));
                pop_cnt++;
                last_pop_pc = bus.instr_pc_o;
                pop_cycles.push_back(cycle);
                exp_pc = exp_pc + 32'd4;
            end
            if (branch) begin
                exp_pc = target & 32'hFFFF_FFFC;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cycle++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n;
        logic [31:0] snap_pc;
        logic [31:0] snap_data;
        int unsigned snap_req;
        int unsigned base_req;
        int unsigned base_pop;

        salt   = $urandom;
        rst_n  = 1'b0;
        enable = 1'b1;
        branch = 1'b0;
        target = '0;
        bus.instr_ready_i = 1'b1;
        cycle   = 0;
        req_cnt = 0;
        pop_cnt = 0;
        exp_pc  = BOOT;
        last_pop_pc = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req",   32'(bus.instr_req_o),   32'd0);
        check("rst_addr",  bus.instr_addr_o,       BOOT);
        check("rst_valid", 32'(bus.instr_valid_o), 32'd0);
        check("rst_rdata", bus.instr_rdata_o,      32'd0);
        check("rst_pc",    bus.instr_pc_o,         32'd0);

        // Boot: three words in order, one every 3 cycles
        rst_n = 1'b1;
        pop_cycles.delete();
        n = 0;
        while (pop_cnt < 3 && n < 40) begin tick(); n++; end
        check("boot_count", pop_cnt, 32'd3);
        if (pop_cycles.size() >= 3) begin
            check("boot_gap1", pop_cycles[1] - pop_cycles[0], 32'd3);
            check("boot_gap2", pop_cycles[2] - pop_cycles[1], 32'd3);
        end

        // Stall: buffer fills to DEPTH, requests stop, head stays put
        bus.instr_ready_i = 1'b0;
        snap_pc = '0; snap_data = '0; snap_req = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 12) begin
                snap_pc   = bus.instr_pc_o;
                snap_data = bus.instr_rdata_o;
                snap_req  = req_cnt;
            end
            tick();
        end
        check("stall_valid", 32'(bus.instr_valid_o), 32'd1);
        check("stall_pc",    bus.instr_pc_o,         snap_pc);
        check("stall_data",  bus.instr_rdata_o,      snap_data);
        check("stall_reqs",  req_cnt - snap_req,     32'd0);
        enable = 1'b0;
        bus.instr_ready_i = 1'b1;
        base_pop = pop_cnt;
        repeat (12) tick();
        check("stall_drain", pop_cnt - base_pop, DEPTH);
        check("drain_empty", 32'(bus.instr_valid_o), 32'd0);

        // Randomized ready/enable/branch traffic
        base_pop = pop_cnt;
        for (int i = 0; i < 400; i++) begin
            bus.instr_ready_i = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 7) != 0);
            branch = ($urandom_range(0, 15) == 0);
            target = $urandom;
            tick();
        end
        branch = 1'b0;
        enable = 1'b1;
        bus.instr_ready_i = 1'b1;
        check("rand_progress", 32'(pop_cnt > base_pop + 20), 32'd1);

        // Branch to 0x203 while a request is in REQ
        n = 0;
        while (!bus.instr_req_o && n < 10) begin tick(); n++; end
        check("br_req_seen", 32'(bus.instr_req_o), 32'd1);
        branch = 1'b1;
        target = 32'h0000_0203;
        tick();
        branch = 1'b0;
        base_pop = pop_cnt;
        n = 0;
        while (pop_cnt == base_pop && n < 20) begin tick(); n++; end
        check("br_pop_seen", pop_cnt - base_pop, 32'd1);
        check("br_first_pc", last_pop_pc, 32'h0000_0200);

        // Address wrap at the top of memory
        branch = 1'b1;
        target = 32'hFFFF_FFFC;
        tick();
        branch = 1'b0;
        req_log.delete();
        n = 0;
        while (req_log.size() < 2 && n < 20) begin tick(); n++; end
        check("wrap_reqs", 32'(req_log.size()), 32'd2);
        if (req_log.size() >= 2) begin
            check("wrap_addr0", req_log[0], 32'hFFFF_FFFC);
            check("wrap_addr1", req_log[1], 32'h0000_0000);
        end
        repeat (8) tick();

        // Reset asserted during RESP
        n = 0;
        while (!bus.instr_req_o && n < 10) begin tick(); n++; end
        check("rr_req_seen", 32'(bus.instr_req_o), 32'd1);
        tick();
        rst_n  = 1'b0;
        exp_pc = BOOT;
        #1;
        check("rr_req",   32'(bus.instr_req_o),   32'd0);
        check("rr_valid", 32'(bus.instr_valid_o), 32'd0);
        check("rr_addr",  bus.instr_addr_o,       BOOT);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        n = 0;
        while (!bus.instr_req_o && n < 10) begin tick(); n++; end
        check("rr_first_req",  32'(bus.instr_req_o), 32'd1);
        check("rr_first_addr", bus.instr_addr_o,     BOOT);

        // Enable dropped during that REQ: its word arrives, nothing more
        enable   = 1'b0;
        base_req = req_cnt;
        base_pop = pop_cnt;
        repeat (15) tick();
        check("en_reqs",  req_cnt - base_req, 32'd1);
        check("en_pops",  pop_cnt - base_pop, 32'd1);
        check("en_pc",    last_pop_pc,        BOOT);
        check("en_valid", 32'(bus.instr_valid_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
